trap_ctrl: RTL

- Initiator side of the machine-mode CSR/trap interface.
- Accepts one decoded system instruction at a time (CSR access, ecall, ebreak, mret) from the EXU.
- Sequences the CSR register file strobes: read, then conditional write, trap entry (intr, intr_NO, intr_epc) or trap return (mret).
- Returns rd write-back data and a PC redirect to the IFU; sits between the decoder/EXU and the CSR file.

---
 rtl/sys_pkg.sv | 51 +++++
 rtl/trap_ctrl_if.sv | 49 ++++
 rtl/csr_alu.sv | 38 +++
 rtl/trap_ctrl.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/sys_pkg.sv
// Shared encodings for the machine-mode trap/CSR sequencer:
// system op codes, CSR sub-ops, CSR numbers, cause codes, FSM states.
package sys_pkg;

  localparam logic [2:0] SYS_NONE   = 3'd0;
  localparam logic [2:0] SYS_CSR    = 3'd1;
  localparam logic [2:0] SYS_ECALL  = 3'd2;
  localparam logic [2:0] SYS_EBREAK = 3'd3;
  localparam logic [2:0] SYS_MRET   = 3'd4;

  localparam logic [2:0] F3_CSRRW  = 3'b001;
  localparam logic [2:0] F3_CSRRS  = 3'b010;
  localparam logic [2:0] F3_CSRRC  = 3'b011;
  localparam logic [2:0] F3_CSRRWI = 3'b101;
  localparam logic [2:0] F3_CSRRSI = 3'b110;
  localparam logic [2:0] F3_CSRRCI = 3'b111;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam logic [3:0] CAUSE_ILLEGAL = 4'd2;
  localparam logic [3:0] CAUSE_BREAK   = 4'd3;
  localparam logic [3:0] CAUSE_ECALL_M = 4'd11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CSR_RD,
    S_CSR_WR,
    S_TRAP,
    S_RET,
    S_REDIR
  } state_t;

  // Only the four implemented CSRs and the six real sub-ops are legal.
  function automatic logic csr_legal(
    input logic [11:0] addr,
    input logic [2:0]  f3
  );
    logic a_ok;
    logic f_ok;
    a_ok = (addr == CSR_MSTATUS) || (addr == CSR_MTVEC) ||
           (addr == CSR_MEPC)    || (addr == CSR_MCAUSE);
    f_ok = (f3 == F3_CSRRW)  || (f3 == F3_CSRRS)  ||
           (f3 == F3_CSRRC)  || (f3 == F3_CSRRWI) ||
           (f3 == F3_CSRRSI) || (f3 == F3_CSRRCI);
    return a_ok && f_ok;
  endfunction

endpackage

// File: rtl/trap_ctrl_if.sv
// EXU/IFU/CSR-file bundle seen by the trap sequencer.
// master = the sequencer, slave = the surrounding pipeline and CSR file.
interface trap_ctrl_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [2:0]            in_op;
  logic [2:0]            in_funct3;
  logic [11:0]           in_csr_addr;
  logic [DATA_WIDTH-1:0] in_src;
  logic                  in_src_zero;
  logic [DATA_WIDTH-1:0] in_pc;
  logic                  done;
  logic                  rd_wen;
  logic [DATA_WIDTH-1:0] rd_wdata;
  logic                  redirect_valid;
  logic [DATA_WIDTH-1:0] redirect_pc;
  logic [DATA_WIDTH-1:0] csr_addr;
  logic                  csr_wen;
  logic [DATA_WIDTH-1:0] csr_wdata;
  logic [DATA_WIDTH-1:0] csr_rdata;
  logic                  intr;
  logic [DATA_WIDTH-1:0] intr_NO;
  logic [DATA_WIDTH-1:0] intr_epc;
  logic [DATA_WIDTH-1:0] intr_mtvec;
  logic                  mret;
  logic [DATA_WIDTH-1:0] mret_mepc;

  modport master (
    input  in_valid, in_op, in_funct3, in_csr_addr,
    input  in_src, in_src_zero, in_pc,
    input  csr_rdata, intr_mtvec, mret_mepc,
    output in_ready, done, rd_wen, rd_wdata,
    output redirect_valid, redirect_pc,
    output csr_addr, csr_wen, csr_wdata,
    output intr, intr_NO, intr_epc, mret
  );

  modport slave (
    output in_valid, in_op, in_funct3, in_csr_addr,
    output in_src, in_src_zero, in_pc,
    output csr_rdata, intr_mtvec, mret_mepc,
    input  in_ready, done, rd_wen, rd_wdata,
    input  redirect_valid, redirect_pc,
    input  csr_addr, csr_wen, csr_wdata,
    input  intr, intr_NO, intr_epc, mret
  );
endinterface

// File: rtl/csr_alu.sv
// Read-modify-write arithmetic for CSR instructions.
// sel is funct3[1:0]: 01 write, 10 set bits, 11 clear bits.
module csr_alu #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [1:0]            sel,
  input  logic [DATA_WIDTH-1:0] old,
  input  logic [DATA_WIDTH-1:0] src,
  input  logic                  src_zero,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  write_en
);

  // Set/clear with a zero operand must not write (side-effect free read).
  always_comb begin
    wdata    = old;
    write_en = 1'b0;
    case (sel)
      2'b01: begin
        wdata    = src;
        write_en = 1'b1;
      end
      2'b10: begin
        wdata    = old | src;
        write_en = !src_zero;
      end
      2'b11: begin
        wdata    = old & ~src;
        write_en = !src_zero;
      end
      default: begin
        wdata    = old;
        write_en = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode system-instruction sequencer: CSR read/write,
// trap entry, mret, and the resulting rd write-back / PC redirect.
module trap_ctrl
  import sys_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  trap_ctrl_if.master  bus
);

  state_t                state;
  state_t                state_n;
  state_t                dec_state;
  logic [3:0]            dec_cause;
  logic                  accept;

  logic [1:0]            sel_q;
  logic [11:0]           addr_q;
  logic [DATA_WIDTH-1:0] src_q;
  logic                  zero_q;
  logic [DATA_WIDTH-1:0] pc_q;
  logic [3:0]            cause_q;
  logic [DATA_WIDTH-1:0] old_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  wen_q;
  logic [DATA_WIDTH-1:0] target_q;

  logic [DATA_WIDTH-1:0] alu_wdata;
  logic                  alu_wen;

  assign accept = bus.in_valid && (state == S_IDLE);

  csr_alu #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_alu (
    .sel      (sel_q),
    .old      (bus.csr_rdata),
    .src      (src_q),
    .src_zero (zero_q),
    .wdata    (alu_wdata),
    .write_en (alu_wen)
  );

  // Classify the incoming op; anything unrecognised traps as illegal.
  always_comb begin
    dec_state = S_TRAP;
    dec_cause = CAUSE_ILLEGAL;
    unique case (1'b1)
      (bus.in_op == SYS_CSR) &&
      csr_legal(bus.in_csr_addr, bus.in_funct3): begin
        dec_state = S_CSR_RD;
      end
      bus.in_op == SYS_ECALL: begin
        dec_cause = CAUSE_ECALL_M;
      end
      bus.in_op == SYS_EBREAK: begin
        dec_cause = CAUSE_BREAK;
      end
      bus.in_op == SYS_MRET: begin
        dec_state = S_RET;
      end
      bus.in_op == SYS_NONE: begin
        dec_cause = CAUSE_ILLEGAL;
      end
      default: begin
        dec_cause = CAUSE_ILLEGAL;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next state and Moore-decoded strobes.
  always_comb begin
    state_n            = state;
    bus.in_ready       = 1'b0;
    bus.done           = 1'b0;
    bus.rd_wen         = 1'b0;
    bus.rd_wdata       = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.csr_addr       = '0;
    bus.csr_wen        = 1'b0;
    bus.csr_wdata      = '0;
    bus.intr           = 1'b0;
    bus.intr_NO        = '0;
    bus.intr_epc       = '0;
    bus.mret           = 1'b0;
    case (state)
      S_IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_n = dec_state;
      end
      S_CSR_RD: begin
        bus.csr_addr = {{(DATA_WIDTH-12){1'b0}}, addr_q};
        state_n      = S_CSR_WR;
      end
      S_CSR_WR: begin
        bus.csr_addr  = {{(DATA_WIDTH-12){1'b0}}, addr_q};
        bus.csr_wdata = wdata_q;
        bus.csr_wen   = wen_q;
        bus.rd_wen    = 1'b1;
        bus.rd_wdata  = old_q;
        bus.done      = 1'b1;
        state_n       = S_IDLE;
      end
      S_TRAP: begin
        bus.intr     = 1'b1;
        bus.intr_NO  = {{(DATA_WIDTH-4){1'b0}}, cause_q};
        bus.intr_epc = pc_q;
        state_n      = S_REDIR;
      end
      S_RET: begin
        bus.mret = 1'b1;
        state_n  = S_REDIR;
      end
      S_REDIR: begin
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = target_q;
        bus.done           = 1'b1;
        state_n            = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // Operand capture at acceptance; CSR result and redirect target
  // captured in the cycle that presents the read / trap strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q    <= '0;
      addr_q   <= '0;
      src_q    <= '0;
      zero_q   <= 1'b0;
      pc_q     <= '0;
      cause_q  <= '0;
      old_q    <= '0;
      wdata_q  <= '0;
      wen_q    <= 1'b0;
      target_q <= '0;
    end else begin
      if (accept) begin
        sel_q   <= bus.in_funct3[1:0];
        addr_q  <= bus.in_csr_addr;
        src_q   <= bus.in_src;
        zero_q  <= bus.in_src_zero;
        pc_q    <= bus.in_pc;
        cause_q <= dec_cause;
      end
      if (state == S_CSR_RD) begin
        old_q   <= bus.csr_rdata;
        wdata_q <= alu_wdata;
        wen_q   <= alu_wen;
      end
      if (state == S_TRAP) target_q <= bus.intr_mtvec;
      if (state == S_RET)  target_q <= bus.mret_mepc;
    end
  end

endmodule
